// File: rtl/riscv_wb_pkg.sv
// Shared constants and types for the register-file writeback path.
package riscv_wb_pkg;

  localparam int unsigned REG_AW     = 5;
  localparam int unsigned REG_DW     = 32;
  localparam int unsigned LD_RESERVE = 1;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [REG_DW-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/regfile_writeback_queue_fwd_match.sv
// Priority search over N {valid, rd, data} candidates; index 0 has highest priority.
module wb_fwd_match #(
  parameter int unsigned N  = 5,
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
) (
  input  logic [N-1:0]  cand_valid,
  input  logic [AW-1:0] cand_rd   [N],
  input  logic [DW-1:0] cand_data [N],
  input  logic [AW-1:0] addr,
  output logic          hit,
  output logic [DW-1:0] data
);

  always_comb begin
    hit  = 1'b0;
    data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!hit && cand_valid[i] && (cand_rd[i] == addr)) begin
        hit  = 1'b1;
        data = cand_data[i];
      end
    end
  end

endmodule

// File: rtl/regfile_writeback_queue.sv
// Writeback FIFO feeding the register-file write port, with forwarding of
// in-flight destinations to decode.
module regfile_writeback_queue
  import riscv_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = REG_AW,
  parameter int unsigned DW    = REG_DW
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     ld_valid,
  input  logic [AW-1:0]            ld_rd,
  input  logic [DW-1:0]            ld_data,
  output logic                     ld_ready,
  input  logic                     alu_valid,
  input  logic [AW-1:0]            alu_rd,
  input  logic [DW-1:0]            alu_data,
  output logic                     alu_ready,
  output logic [AW-1:0]            write_reg,
  output logic                     regwrite,
  output logic [DW-1:0]            writedata,
  input  logic [AW-1:0]            rd_addr1,
  input  logic [AW-1:0]            rd_addr2,
  output logic                     fwd_hit1,
  output logic [DW-1:0]            fwd_data1,
  output logic                     fwd_hit2,
  output logic [DW-1:0]            fwd_data2,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0] q_rd   [DEPTH];
  logic [DW-1:0] q_data [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic          push_ld;
  logic          push_alu;
  logic          pop;

  // Readiness uses only the registered count; the ALU limit keeps one slot for a load.
  assign ld_ready  = (count < CW'(DEPTH));
  assign alu_ready = (count < CW'(DEPTH - LD_RESERVE));
  assign push_ld   = ld_valid  && ld_ready;
  assign push_alu  = alu_valid && alu_ready;
  assign pop       = (count != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      regwrite  <= 1'b0;
      write_reg <= '0;
      writedata <= '0;
    end else begin
      if (push_ld) begin
        q_rd[tail]   <= ld_rd;
        q_data[tail] <= ld_data;
      end
      // The load is older, so the ALU result goes in the slot after it.
      if (push_alu) begin
        q_rd[tail + PW'(push_ld)]   <= alu_rd;
        q_data[tail + PW'(push_ld)] <= alu_data;
      end
      tail     <= tail + PW'(push_ld) + PW'(push_alu);
      regwrite <= pop;
      if (pop) begin
        write_reg <= q_rd[head];
        writedata <= q_data[head];
        head      <= head + PW'(1);
      end
      count <= count + CW'(push_ld) + CW'(push_alu) - CW'(pop);
    end
  end

  // Candidate j is the j-th newest queue entry; the output register is last.
  logic [DEPTH:0] cand_valid;
  logic [AW-1:0]  cand_rd   [DEPTH+1];
  logic [DW-1:0]  cand_data [DEPTH+1];

  always_comb begin
    for (int unsigned j = 0; j < DEPTH; j++) begin
      cand_valid[j] = (CW'(j) < count);
      cand_rd[j]    = q_rd[PW'(tail - PW'(j + 1))];
      cand_data[j]  = q_data[PW'(tail - PW'(j + 1))];
    end
    cand_valid[DEPTH] = regwrite;
    cand_rd[DEPTH]    = write_reg;
    cand_data[DEPTH]  = writedata;
  end

  wb_fwd_match #(.N(DEPTH + 1), .AW(AW), .DW(DW)) u_fwd1 (
    .cand_valid (cand_valid),
    .cand_rd    (cand_rd),
    .cand_data  (cand_data),
    .addr       (rd_addr1),
    .hit        (fwd_hit1),
    .data       (fwd_data1)
  );

  wb_fwd_match #(.N(DEPTH + 1), .AW(AW), .DW(DW)) u_fwd2 (
    .cand_valid (cand_valid),
    .cand_rd    (cand_rd),
    .cand_data  (cand_data),
    .addr       (rd_addr2),
    .hit        (fwd_hit2),
    .data       (fwd_data2)
  );

endmodule

// File: tb/tb_regfile_writeback_queue.sv
// Scoreboard bench for regfile_writeback_queue: accepted results are queued
// when driven and compared against every committed register write.
module tb_regfile_writeback_queue;
  import riscv_wb_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic        ld_valid, alu_valid;
  logic [4:0]  ld_rd, alu_rd;
  logic [31:0] ld_data, alu_data;
  logic        ld_ready, alu_ready;
  logic [4:0]  write_reg;
  logic        regwrite;
  logic [31:0] writedata;
  logic [4:0]  rd_addr1, rd_addr2;
  logic        fwd_hit1, fwd_hit2;
  logic [31:0] fwd_data1, fwd_data2;
  logic [2:0]  count;

  int unsigned vectors = 0;
  int unsigned miscompares = 0;
  int unsigned m_cnt = 0;
  wb_entry_t   exp_q[$];

  regfile_writeback_queue #(.DEPTH(DEPTH), .AW(5), .DW(32)) dut (
    .clk       (clk),
    .reset     (reset),
    .ld_valid  (ld_valid),
    .ld_rd     (ld_rd),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .alu_valid (alu_valid),
    .alu_rd    (alu_rd),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .write_reg (write_reg),
    .regwrite  (regwrite),
    .writedata (writedata),
    .rd_addr1  (rd_addr1),
    .rd_addr2  (rd_addr2),
    .fwd_hit1  (fwd_hit1),
    .fwd_data1 (fwd_data1),
    .fwd_hit2  (fwd_hit2),
    .fwd_data2 (fwd_data2),
    .count     (count)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Commit monitor: every regwrite must match the oldest outstanding result.
  always @(negedge clk) begin
    if (count > 3'(DEPTH)) begin
      miscompares++;
      $display("FAIL count_bound: count=%0d exceeds %0d", count, DEPTH);
    end
    if (regwrite === 1'b1) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL commit_unexpected: rd=%0d data=%h with no outstanding result", write_reg, writedata);
      end else begin
        wb_entry_t e;
        e = exp_q.pop_front();
        if (write_reg !== e.rd || writedata !== e.data) begin
          miscompares++;
          $display("FAIL commit: got rd=%0d data=%h, expected rd=%0d data=%h",
                   write_reg, writedata, e.rd, e.data);
        end
      end
    end
  end

  // Advance one edge, updating the reference occupancy and expected queue.
  task automatic step();
    bit lp, ap;
    int unsigned keep;
    lp = ld_valid  && (m_cnt < DEPTH);
    ap = alu_valid && (m_cnt < DEPTH - 1);
    if (reset) begin
      keep = (regwrite === 1'b1) ? 1 : 0;
      while (exp_q.size() > keep) void'(exp_q.pop_back());
      m_cnt = 0;
    end else begin
      if (lp) exp_q.push_back('{rd: ld_rd, data: ld_data});
      if (ap) exp_q.push_back('{rd: alu_rd, data: alu_data});
      m_cnt = m_cnt + int'(lp) + int'(ap) - ((m_cnt > 0) ? 1 : 0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int unsigned n = 0;
    ld_valid  = 1'b0;
    alu_valid = 1'b0;
    while ((m_cnt != 0 || regwrite === 1'b1) && n < 16) begin
      step();
      n++;
    end
    vectors++;
    if (count !== 3'd0 || regwrite !== 1'b0) begin
      miscompares++;
      $display("FAIL drain: count=%0d regwrite=%b after %0d cycles, required 0/0", count, regwrite, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ld_valid = 1'b1; ld_rd = 5'd1; ld_data = 32'h1111_0001;
    alu_valid = 1'b1; alu_rd = 5'd2; alu_data = 32'h2222_0002;
    rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    step();
    step();
    vectors++;
    if (count !== 3'd0 || regwrite !== 1'b0 || write_reg !== 5'd0 || writedata !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_state: count=%0d regwrite=%b write_reg=%0d writedata=%h, required all zero",
               count, regwrite, write_reg, writedata);
    end
    vectors++;
    if (ld_ready !== 1'b1 || alu_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: ld_ready=%b alu_ready=%b, required 1/1", ld_ready, alu_ready);
    end
    reset = 1'b0;
    ld_valid = 1'b0;
    alu_valid = 1'b0;
    step();
    vectors++;
    if (count !== 3'd0 || regwrite !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_nothing_enqueued: count=%0d regwrite=%b, required 0/0", count, regwrite);
    end
  endtask

  task automatic test_single_alu();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'hDEAD_BEEF;
    step();
    alu_valid = 1'b0;
    vectors++;
    if (regwrite !== 1'b0 || count !== 3'd1) begin
      miscompares++;
      $display("FAIL single_latency: regwrite=%b count=%0d, required 0/1", regwrite, count);
    end
    step();
    vectors++;
    if (regwrite !== 1'b1 || write_reg !== 5'd5 || writedata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL single_commit: regwrite=%b rd=%0d data=%h, required 1/5/deadbeef",
               regwrite, write_reg, writedata);
    end
    step();
    vectors++;
    if (regwrite !== 1'b0 || write_reg !== 5'd5 || writedata !== 32'hDEAD_BEEF) begin
      miscompares++;
      $display("FAIL single_hold: regwrite=%b rd=%0d data=%h, required 0/5/deadbeef",
               regwrite, write_reg, writedata);
    end
  endtask

  task automatic test_simultaneous();
    ld_valid  = 1'b1; ld_rd  = 5'd3; ld_data  = 32'h11;
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'h22;
    rd_addr1  = 5'd3;
    #1;
    vectors++;
    if (fwd_hit1 !== 1'b0) begin
      miscompares++;
      $display("FAIL sim_not_visible: fwd_hit1=%b before edge, required 0", fwd_hit1);
    end
    step();
    ld_valid = 1'b0; alu_valid = 1'b0;
    vectors++;
    if (count !== 3'd2 || fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h22) begin
      miscompares++;
      $display("FAIL sim_pending: count=%0d hit=%b data=%h, required 2/1/22", count, fwd_hit1, fwd_data1);
    end
    step();
    vectors++;
    if (writedata !== 32'h11 || fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h22) begin
      miscompares++;
      $display("FAIL sim_first_commit: writedata=%h fwd=%b/%h, required 11 and 1/22",
               writedata, fwd_hit1, fwd_data1);
    end
    step();
    vectors++;
    if (regwrite !== 1'b1 || writedata !== 32'h22 || fwd_hit1 !== 1'b1 || fwd_data1 !== 32'h22) begin
      miscompares++;
      $display("FAIL sim_final_commit: regwrite=%b writedata=%h fwd=%b/%h, required 1/22 and 1/22",
               regwrite, writedata, fwd_hit1, fwd_data1);
    end
    step();
    vectors++;
    if (fwd_hit1 !== 1'b0 || fwd_data1 !== 32'd0) begin
      miscompares++;
      $display("FAIL sim_retired: fwd=%b/%h, required 0/0", fwd_hit1, fwd_data1);
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < 12; i++) begin
      ld_valid  = 1'b1; ld_rd  = 5'($urandom_range(0, 31)); ld_data  = $urandom;
      alu_valid = 1'b1; alu_rd = 5'($urandom_range(0, 31)); alu_data = $urandom;
      vectors++;
      if (ld_ready !== (m_cnt < DEPTH) || alu_ready !== (m_cnt < DEPTH - 1)) begin
        miscompares++;
        $display("FAIL fill_ready: cycle %0d ld_ready=%b alu_ready=%b, required %b/%b",
                 i, ld_ready, alu_ready, (m_cnt < DEPTH), (m_cnt < DEPTH - 1));
      end
      step();
      vectors++;
      if (count !== 3'(m_cnt)) begin
        miscompares++;
        $display("FAIL fill_count: cycle %0d count=%0d, required %0d", i, count, m_cnt);
      end
    end
    drain();
  endtask

  task automatic test_fwd_miss_hit();
    alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hA5A5_0007;
    step();
    alu_valid = 1'b0;
    rd_addr2 = 5'd8;
    #1;
    vectors++;
    if (fwd_hit2 !== 1'b0 || fwd_data2 !== 32'd0) begin
      miscompares++;
      $display("FAIL fwd_miss: hit2=%b data2=%h, required 0/0", fwd_hit2, fwd_data2);
    end
    rd_addr2 = 5'd7;
    #1;
    vectors++;
    if (fwd_hit2 !== 1'b1 || fwd_data2 !== 32'hA5A5_0007) begin
      miscompares++;
      $display("FAIL fwd_hit: hit2=%b data2=%h, required 1/a5a50007", fwd_hit2, fwd_data2);
    end
    drain();
  endtask

  task automatic test_reset_mid_drain();
    ld_valid  = 1'b1; ld_rd  = 5'd10; ld_data  = 32'h0A;
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'h0B;
    step();
    ld_rd  = 5'd12; ld_data  = 32'h0C;
    alu_rd = 5'd13; alu_data = 32'h0D;
    step();
    vectors++;
    if (count !== 3'd3) begin
      miscompares++;
      $display("FAIL mid_pending: count=%0d, required 3", count);
    end
    reset = 1'b1;
    ld_rd = 5'd14; ld_data = 32'h0E;
    step();
    reset = 1'b0;
    ld_valid = 1'b0; alu_valid = 1'b0;
    vectors++;
    if (regwrite !== 1'b0 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL mid_reset: regwrite=%b count=%0d, required 0/0", regwrite, count);
    end
    for (int i = 0; i < 5; i++) step();
    vectors++;
    if (exp_q.size() != 0 || count !== 3'd0) begin
      miscompares++;
      $display("FAIL mid_discard: %0d results outstanding, count=%0d, required 0/0", exp_q.size(), count);
    end
  endtask

  initial begin
    test_reset();
    test_single_alu();
    test_simultaneous();
    test_fill();
    test_fwd_miss_hit();
    test_reset_mid_drain();
    step();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
